// File: rtl/frame_adj_sched.sv
// Frame-synchronous pixel-adjust scheduler: accumulates adjust pulses during a frame and
// commits them at the frame boundary. Optional sticky overrun flag: FRAME_ADJ_OVR_EN.
module frame_adj_sched #(
    parameter int BW        = 8,
    parameter int B_STEP    = 8,
    parameter int CW        = 4,
    parameter int C_STEP    = 1,
    parameter int C_DEFAULT = 4,
    parameter int PEND_MAX  = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 frame_en,
    input  logic                 en_adj,
    input  logic                 binc,
    input  logic                 bdec,
    input  logic                 cinc,
    input  logic                 cdec,
    input  logic [3:0]           clr_sel,
    input  logic                 upd_ready,
    output logic signed [BW-1:0] bright_off,
    output logic [CW-1:0]        contrast_gain,
    output logic [1:0]           clr_mode,
`ifdef FRAME_ADJ_OVR_EN
    output logic                 ovr,
`endif
    output logic                 upd_valid
);

    localparam int SBW = BW + 4;
    localparam int SCW = CW + 4;
    localparam logic [3:0] P_MAX = 4'(PEND_MAX);
    localparam logic [3:0] P_MIN = 4'(-PEND_MAX);
    localparam logic signed [SBW-1:0] B_HI = SBW'(2**(BW-1) - 1);
    localparam logic signed [SBW-1:0] B_LO = SBW'(-(2**(BW-1)));
    localparam logic signed [SCW-1:0] C_HI = SCW'(2**CW - 1);

    typedef enum logic [1:0] {S_IDLE, S_COMMIT, S_HOLD} state_t;

    state_t                r_state, w_state_nxt;
    logic signed [BW-1:0]  r_bright;
    logic [CW-1:0]         r_gain;
    logic [1:0]            r_mode;
    logic                  r_valid;
    logic [3:0]            r_pend_b, r_pend_c;
    logic                  r_clr_pend;
    logic [1:0]            r_clr_idx;

    logic                  w_commit, w_pending, w_clr_any;
    logic [1:0]            w_clr_lsb;
    logic [3:0]            w_b_base, w_c_base, w_pend_b_nxt, w_pend_c_nxt;
    logic signed [SBW-1:0] w_b_sum;
    logic signed [SCW-1:0] w_c_sum;
    logic [BW-1:0]         w_b_clamp;
    logic [CW-1:0]         w_c_clamp;

    function automatic logic [3:0] f_acc(input logic [3:0] base, input logic up, input logic dn);
        f_acc = base;
        if (up && !dn && base != P_MAX)
            f_acc = base + 4'd1;
        else if (dn && !up && base != P_MIN)
            f_acc = base - 4'd1;
    endfunction

    assign w_commit  = (r_state == S_COMMIT);
    assign w_pending = (r_pend_b != 4'd0) || (r_pend_c != 4'd0) || r_clr_pend;
    assign w_clr_any = |clr_sel;

    // The commit cycle restarts pending from zero so its own pulses land in the next frame.
    assign w_b_base = w_commit ? 4'd0 : r_pend_b;
    assign w_c_base = w_commit ? 4'd0 : r_pend_c;

    always_comb begin
        w_pend_b_nxt = '0;
        w_pend_c_nxt = '0;
        if (en_adj) begin
            w_pend_b_nxt = f_acc(w_b_base, binc, bdec);
            w_pend_c_nxt = f_acc(w_c_base, cinc, cdec);
        end
    end

    always_comb begin
        w_clr_lsb = 2'd3;
        if (clr_sel[0])      w_clr_lsb = 2'd0;
        else if (clr_sel[1]) w_clr_lsb = 2'd1;
        else if (clr_sel[2]) w_clr_lsb = 2'd2;
    end

    always_comb begin
        w_b_sum = $signed({{4{r_bright[BW-1]}}, r_bright})
                + $signed({{(SBW-4){r_pend_b[3]}}, r_pend_b}) * $signed(SBW'(B_STEP));
        w_c_sum = $signed({4'b0000, r_gain})
                + $signed({{(SCW-4){r_pend_c[3]}}, r_pend_c}) * $signed(SCW'(C_STEP));
        if (w_b_sum > B_HI)      w_b_clamp = B_HI[BW-1:0];
        else if (w_b_sum < B_LO) w_b_clamp = B_LO[BW-1:0];
        else                     w_b_clamp = w_b_sum[BW-1:0];
        if (w_c_sum > C_HI)               w_c_clamp = C_HI[CW-1:0];
        else if (w_c_sum < SCW'(0))       w_c_clamp = '0;
        else                              w_c_clamp = w_c_sum[CW-1:0];
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (frame_en && w_pending) w_state_nxt = S_COMMIT;
            S_COMMIT: w_state_nxt = S_HOLD;
            S_HOLD:   if (upd_ready) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_bright   <= '0;
            r_gain     <= CW'(C_DEFAULT);
            r_mode     <= '0;
            r_valid    <= 1'b0;
            r_pend_b   <= '0;
            r_pend_c   <= '0;
            r_clr_pend <= 1'b0;
            r_clr_idx  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_pend_b   <= w_pend_b_nxt;
            r_pend_c   <= w_pend_c_nxt;
            r_clr_pend <= w_clr_any | (r_clr_pend & ~w_commit);
            if (w_clr_any)
                r_clr_idx <= w_clr_lsb;
            if (w_commit) begin
                r_bright <= w_b_clamp;
                r_gain   <= w_c_clamp;
                if (r_clr_pend)
                    r_mode <= r_clr_idx;
                r_valid  <= 1'b1;
            end else if (r_state == S_HOLD && upd_ready) begin
                r_valid  <= 1'b0;
            end
        end
    end

`ifdef FRAME_ADJ_OVR_EN
    logic r_ovr;
    logic w_drop;

    assign w_drop = en_adj && (
        (binc && !bdec && w_b_base == P_MAX) || (bdec && !binc && w_b_base == P_MIN) ||
        (cinc && !cdec && w_c_base == P_MAX) || (cdec && !cinc && w_c_base == P_MIN));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_ovr <= 1'b0;
        else if (w_drop || (frame_en && r_state != S_IDLE))
            r_ovr <= 1'b1;
    end

    assign ovr = r_ovr;
`endif

    assign bright_off    = r_bright;
    assign contrast_gain = r_gain;
    assign clr_mode      = r_mode;
    assign upd_valid     = r_valid;

endmodule
